// File: rtl/rv32i_mem_pkg.sv
// Shared memory-access definitions for the data-memory bridge and the LSU side:
// bridge state encoding, lane/wait widths and the lane-scan helper.
package rv32i_mem_pkg;

    localparam int LANE_W    = 2;
    localparam int NUM_LANES = 4;
    localparam int WAIT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic              vld;
        logic [LANE_W-1:0] lane;
    } lane_sel_t;

    // Lowest enabled lane at or above 'start'; vld=0 when none remain.
    function automatic lane_sel_t find_lane(input logic [NUM_LANES-1:0] be,
                                            input logic [LANE_W:0]      start);
        lane_sel_t sel;
        sel = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (be[k] && ((LANE_W+1)'(k) >= start)) begin
                sel.vld  = 1'b1;
                sel.lane = LANE_W'(k);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rv32i_dmem_bridge_if.sv
// Core-side and external byte-bus signals of the data-memory bridge.
interface rv32i_dmem_bridge_if #(parameter int ADDR_W = 16);

    logic              req_i;
    logic [31:0]       mem_addr_i;
    logic              we_mem_i;
    logic              be0_i;
    logic              be1_i;
    logic              be2_i;
    logic              be3_i;
    logic [31:0]       wmem_i;
    logic [31:0]       rmem_o;
    logic              ack_o;
    logic              busy_o;
    logic [ADDR_W-1:0] ext_addr_o;
    logic [7:0]        ext_dat_o;
    logic [7:0]        ext_dat_i;
    logic              ext_we_o;
    logic              ext_oe_o;

    modport slave (
        input  req_i, mem_addr_i, we_mem_i, be0_i, be1_i, be2_i, be3_i, wmem_i, ext_dat_i,
        output rmem_o, ack_o, busy_o, ext_addr_o, ext_dat_o, ext_we_o, ext_oe_o
    );

    modport master (
        output req_i, mem_addr_i, we_mem_i, be0_i, be1_i, be2_i, be3_i, wmem_i, ext_dat_i,
        input  rmem_o, ack_o, busy_o, ext_addr_o, ext_dat_o, ext_we_o, ext_oe_o
    );

endinterface

// File: rtl/rv32i_wait_ctr.sv
// Per-lane wait-state counter: loaded at lane start, counts down, flags the lane's last cycle.
module rv32i_wait_ctr
    import rv32i_mem_pkg::*;
#(
    parameter int WIDTH = WAIT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_last
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/rv32i_dmem_bridge.sv
// Bridges 32-bit lane-enabled loads/stores onto an 8-bit external bus,
// one enabled lane at a time in ascending order, with fixed wait states per byte.
module rv32i_dmem_bridge
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rv32i_dmem_bridge_if.slave  bus
);

    mem_state_e          r_state;
    mem_state_e          w_state_nxt;
    logic [ADDR_W-3:0]   r_addr;
    logic                r_we;
    logic [3:0]          r_be;
    logic [31:0]         r_wdat;
    logic [LANE_W-1:0]   r_lane;
    logic [31:0]         r_rbuf;
    logic [31:0]         r_rmem;
    logic [31:0]         w_rbuf_nxt;
    logic [3:0]          w_be;
    lane_sel_t           w_first;
    lane_sel_t           w_next;
    logic                w_start;
    logic                w_lane_last;
    logic                w_lane_done;
    logic                w_unused;

    assign w_be        = {bus.be3_i, bus.be2_i, bus.be1_i, bus.be0_i};
    assign w_first     = find_lane(w_be, '0);
    assign w_next      = find_lane(r_be, {1'b0, r_lane} + (LANE_W+1)'(1));
    assign w_start     = (r_state == ST_IDLE) && bus.req_i && w_first.vld;
    assign w_lane_done = (r_state == ST_ACCESS) && w_lane_last;
    assign w_unused    = ^{bus.mem_addr_i[31:ADDR_W], bus.mem_addr_i[1:0]};

    rv32i_wait_ctr #(.WIDTH(WAIT_W)) u_wait_ctr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_load     (w_start || (w_lane_done && w_next.vld)),
        .i_dec      ((r_state == ST_ACCESS) && !w_lane_last),
        .i_load_val (WAIT_W'(WAIT_CYCLES)),
        .o_last     (w_lane_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_i) begin
                    w_state_nxt = w_first.vld ? ST_ACCESS : ST_ACK;
                end
            end
            ST_ACCESS: begin
                if (w_lane_last && !w_next.vld) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read buffer with the byte arriving on the current lane merged in.
    always_comb begin
        w_rbuf_nxt = r_rbuf;
        w_rbuf_nxt[8*r_lane +: 8] = bus.ext_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr <= '0;
            r_we   <= 1'b0;
            r_be   <= '0;
            r_wdat <= '0;
            r_lane <= '0;
            r_rbuf <= '0;
            r_rmem <= '0;
        end else if (w_start) begin
            r_addr <= bus.mem_addr_i[ADDR_W-1:2];
            r_we   <= bus.we_mem_i;
            r_be   <= w_be;
            r_wdat <= bus.wmem_i;
            r_lane <= w_first.lane;
            r_rbuf <= '0;
        end else if (w_lane_done) begin
            if (!r_we) begin
                r_rbuf <= w_rbuf_nxt;
            end
            if (w_next.vld) begin
                r_lane <= w_next.lane;
            end else if (!r_we) begin
                r_rmem <= w_rbuf_nxt;
            end
        end
    end

    // Strobes decode straight from state so reset clears them without a clock.
    assign bus.ack_o      = (r_state == ST_ACK);
    assign bus.busy_o     = (r_state != ST_IDLE);
    assign bus.ext_we_o   = (r_state == ST_ACCESS) && r_we;
    assign bus.ext_oe_o   = (r_state == ST_ACCESS) && !r_we;
    assign bus.ext_addr_o = {r_addr, r_lane};
    assign bus.ext_dat_o  = r_wdat[8*r_lane +: 8];
    assign bus.rmem_o     = r_rmem;

endmodule

// File: doc/rv32i_dmem_bridge.md
RV32I_DMEM_BRIDGE -- requirements
Module: rv32i_dmem_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, external byte-address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra cycles held per external byte access (0..15).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as below.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 req_i  in  1  core access request, sampled only in IDLE.
REQ-007 mem_addr_i  in  32  word address from the load/store unit; bits [1:0] and bits above ADDR_W-1 are ignored.
REQ-008 we_mem_i  in  1  1 = write, 0 = read.
REQ-009 be0_i..be3_i  in  1 each  byte-lane enables; lane k = bits [8k+7:8k].
REQ-010 wmem_i  in  32  lane-aligned write data.
REQ-011 rmem_o  out  32  lane-aligned read data.
REQ-012 ack_o  out  1  one-cycle completion pulse.
REQ-013 busy_o  out  1  access in progress.
REQ-014 ext_addr_o  out  ADDR_W  external byte address.
REQ-015 ext_dat_o  out  8  external write byte.
REQ-016 ext_dat_i  in  8  external read byte.
REQ-017 ext_we_o  out  1  external write strobe.
REQ-018 ext_oe_o  out  1  external output enable.

Function
REQ-019 SHALL implement states IDLE, ACCESS, ACK.
REQ-020 IDLE -> ACCESS on req_i=1 with at least one enable set; in that cycle the bridge SHALL latch addr, we, enables and wmem_i.
REQ-021 IDLE -> ACK on req_i=1 with all enables 0; no external access SHALL occur.
REQ-022 ACCESS SHALL visit lanes 0..3 in ascending order, skipping disabled lanes.
REQ-023 Each enabled lane SHALL occupy exactly WAIT_CYCLES+1 cycles, with ext_addr_o = {addr[ADDR_W-1:2], k} held constant for those cycles.
REQ-024 Write lane: ext_dat_o = wmem byte k and ext_we_o=1 for all cycles of the lane; ext_oe_o=0.
REQ-025 Read lane: ext_oe_o=1 for all cycles of the lane; ext_dat_i SHALL be captured on the last cycle of the lane into read-buffer byte k.
REQ-026 ACCESS -> ACK after the final enabled lane; ack_o=1 for exactly one cycle, then the bridge returns to IDLE.
REQ-027 Latency: with a request accepted at edge N and L enabled lanes, ack_o SHALL be high in cycle N+1+L*(WAIT_CYCLES+1).
REQ-028 On a read, rmem_o SHALL update at the ACK cycle: enabled lanes carry captured bytes, disabled lanes read 0. It SHALL then hold until the next read completes.
REQ-029 On a write, rmem_o SHALL remain unchanged.
REQ-030 busy_o SHALL be 1 in ACCESS and ACK, and 0 in IDLE.
REQ-031 req_i SHALL be ignored while busy_o=1; a request held high across ACK SHALL be accepted in the first IDLE cycle.
REQ-032 ext_we_o and ext_oe_o SHALL never both be 1.
REQ-033 Outside ACCESS, ext_we_o and ext_oe_o SHALL be 0, and ext_addr_o and ext_dat_o SHALL hold their last values.

Reset
REQ-034 While rst_ni=0: state IDLE; rmem_o, ext_addr_o and ext_dat_o = 0; ack_o, busy_o, ext_we_o and ext_oe_o = 0, asynchronously.
REQ-035 Reset during ACCESS SHALL abort the access immediately, with no ack_o and no further strobes after release.
REQ-036 After release, the first request SHALL be accepted on the first rising edge with rst_ni=1.

Structure
REQ-037 State encodings and the default lane and wait widths SHALL live in the shared rv32i_mem_pkg package, reused by the LSU side.
REQ-038 A sub-module rv32i_wait_ctr SHALL provide the per-lane wait-state counter (load, decrement, last-cycle flag).

Verification
REQ-039 Word write: addr=0x0000_0104, be=1111, wmem=0xDEADBEEF, WAIT=1 -> bytes EF, BE, AD, DE written to 0x104..0x107; ext_we_o high 8 cycles; ack in cycle N+9.
REQ-040 Byte read: addr=0x0000_0010, be=0100, ext memory[0x12]=0x5A -> rmem_o=0x005A0000; ack in cycle N+3.
REQ-041 Half read with sparse enables: be=1100, memory[0x22..0x23]=0x34, 0x12 -> only 0x22 and 0x23 accessed; rmem_o=0x12340000.
REQ-042 Zero enables: req with be=0000 -> ack in cycle N+1; ext_we_o and ext_oe_o stay 0; rmem_o unchanged.
REQ-043 Reset mid-write: rst_ni low during lane 1 of a word write -> ext_we_o falls without a clock edge; no ack; only byte 0x..0 (and, if in progress, 0x..1) altered.
REQ-044 Back-to-back: req_i held high for 20 cycles -> two full accesses, each separated by exactly one ACK cycle and one IDLE acceptance, with no overlapped strobes.
